// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch channel: word address and request out, ready and data back.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_ready;
  logic [15:0]       imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: fetches one word into IR, holds it for execute, then
// advances the PC (with optional PC-relative branch) or halts.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   FETCH   | request outstanding at pc; wait for imem_ready, capture into ir
//   EXEC    | ir valid for execute; resolve branch / halt unless stalled
//   HALT    | fetch stopped after a PC_write=0 instruction; only rst exits
module instr_fetch #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     imem,
  output logic [3:0]        Opcode,
  output logic [15:0]       ir,
  output logic              instr_valid,
  input  logic              Branch,
  input  logic              Branch_not,
  input  logic              PC_write,
  input  logic              zero,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       ir_nxt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_inc;
  logic              taken;

  // Branch offset is ir[7:0] sign-extended, or truncated when the PC is narrower.
  generate
    if (ADDR_W > 8) begin : g_sext
      assign br_off = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
    end else begin : g_trunc
      assign br_off = ir[ADDR_W-1:0];
    end
  endgenerate

  assign pc_inc = pc + ADDR_W'(1);
  assign taken  = (Branch & zero) | (Branch_not & ~zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    halted        = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          ir_nxt    = imem.imem_rdata;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (PC_write) begin
            pc_nxt    = taken ? (pc_inc + br_off) : pc_inc;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign imem.imem_addr = pc;
  assign Opcode         = ir[15:12];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  ADDR_W  word address of the instruction being fetched.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_ready  input  1  memory reports imem_rdata valid for the current request.
REQ-008 imem_rdata  input  16  instruction word returned by memory.
REQ-009 Opcode  output  4  IR[15:12], fed to the controller decode.
REQ-010 ir  output  16  held instruction register.
REQ-011 instr_valid  output  1  IR holds an instruction in its execute cycle.
REQ-012 Branch, Branch_not, PC_write  input  1 each  controller decode outputs for the current Opcode.
REQ-013 zero  input  1  ALU zero flag for the current instruction.
REQ-014 stall  input  1  hold current instruction in execute.
REQ-015 pc  output  ADDR_W  address of the instruction in IR.
REQ-016 halted  output  1  fetch stopped after a PC_write=0 instruction.

Function
REQ-017 The block SHALL implement states FETCH, EXEC, HALT.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; instr_valid SHALL be 0.
REQ-019 imem_req SHALL stay 1 and imem_addr SHALL stay stable until a cycle with imem_ready=1.
REQ-020 imem_ready SHALL be ignored while imem_req=0.
REQ-021 On FETCH with imem_ready=1: ir <= imem_rdata, next state EXEC; ready in the first request cycle is legal (fetch latency 1 cycle minimum).
REQ-022 In EXEC, instr_valid SHALL be 1, imem_req 0, and Opcode SHALL equal ir[15:12] combinationally.
REQ-023 In EXEC with stall=1: state, pc, ir SHALL hold.
REQ-024 In EXEC with stall=0 and PC_write=1: taken = (Branch & zero) | (Branch_not & ~zero); pc <= taken ? pc+1+sext(ir[7:0]) : pc+1; next state FETCH.
REQ-025 PC arithmetic SHALL be modulo 2^ADDR_W (wrap-around, no error); sext(ir[7:0]) SHALL be sign-extended or truncated to ADDR_W.
REQ-026 Branch and Branch_not both 1 SHALL yield taken=1 regardless of zero.
REQ-027 In EXEC with stall=0 and PC_write=0: pc SHALL hold, next state HALT.
REQ-028 In HALT: halted=1, imem_req=0, instr_valid=0, pc and ir hold; only rst leaves HALT.
REQ-029 Stall SHALL have no effect outside EXEC; Branch/Branch_not/PC_write/zero SHALL be sampled only in EXEC with stall=0.
REQ-030 Throughput SHALL be one instruction per two cycles with zero-wait memory.

Reset
REQ-031 rst=1 SHALL, at the next edge, set state FETCH, pc=RESET_PC, ir=16'h0000.
REQ-032 Output values after reset: imem_req=1, imem_addr=RESET_PC, instr_valid=0, halted=0, Opcode=0.
REQ-033 rst SHALL override imem_ready, stall and all other inputs in the same cycle.
REQ-034 Reset during an outstanding fetch SHALL abandon it; any later imem_ready for it is not captured unless the restarted request is pending.

Verification
REQ-035 Reset, imem_ready tied 1, memory returns 16'h1123 at every address, PC_write=1, Branch=Branch_not=0 -> pc steps 0,1,2,... every 2 cycles; instr_valid toggles 0,1; Opcode=4'h1.
REQ-036 imem_ready held 0 for 3 cycles after reset -> imem_req=1 and imem_addr=0 all 4 cycles; ir loaded only in 4th cycle.
REQ-037 pc=8'h10, ir=16'hB0FE, Branch=1, zero=1, PC_write=1 -> next pc=8'h0F; same with zero=0 -> 8'h11.
REQ-038 pc=8'hFF, non-branch, PC_write=1 -> pc wraps to 8'h00; pc=8'hFE, ir[7:0]=8'h05, taken -> pc=8'h04.
REQ-039 EXEC with stall=1 for 2 cycles then PC_write=0 -> instr_valid=1 for 3 cycles, then halted=1, imem_req=0 indefinitely; rst -> pc=0, halted=0.
REQ-040 rst asserted in EXEC with stall=1 and Branch=1 -> next cycle state FETCH, pc=RESET_PC, ir=0.
